// File: rtl/write_ptr_flag_block_if.sv
// Write-side port bundle of the async FIFO pointer/flag block.
// The slave modport is the block's own view of these signals.
interface write_ptr_flag_block_if #(
    parameter int ADDR_SIZE = 3
);
    logic                 write_inc_i;
    logic [ADDR_SIZE:0]   read_pointer_i;
    logic [ADDR_SIZE:0]   almost_full_thresh_i;
    logic                 write_ovf_clear_i;
    logic                 write_accept_o;
    logic [ADDR_SIZE-1:0] write_addr_o;
    logic [ADDR_SIZE:0]   write_pointer_o;
    logic                 write_full_o;
    logic                 write_almost_full_o;
    logic [ADDR_SIZE:0]   write_level_o;
    logic                 write_overflow_o;

    modport slave (
        input  write_inc_i, read_pointer_i, almost_full_thresh_i, write_ovf_clear_i,
        output write_accept_o, write_addr_o, write_pointer_o, write_full_o,
               write_almost_full_o, write_level_o, write_overflow_o
    );

    modport master (
        output write_inc_i, read_pointer_i, almost_full_thresh_i, write_ovf_clear_i,
        input  write_accept_o, write_addr_o, write_pointer_o, write_full_o,
               write_almost_full_o, write_level_o, write_overflow_o
    );
endinterface

// File: rtl/write_ptr_flag_block.sv
// Write-domain half of an async FIFO: binary/Gray write pointer, read-pointer
// synchroniser, and registered fill level, full, almost-full and sticky overflow.
module write_ptr_flag_block #(
    parameter int ADDR_SIZE   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    write_clock_i,
    input  logic                    write_reset_i,
    write_ptr_flag_block_if.slave   bus
);
    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);

    function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_sync [SYNC_STAGES];
    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic [PW-1:0] r_level;
    logic          r_full;
    logic          r_almost_full;
    logic          r_overflow;

    logic          w_accept;
    logic          w_ovf_event;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_level_next;
    logic [PW-1:0] w_thresh_eff;

    assign w_accept     = bus.write_inc_i & ~r_full;
    assign w_ovf_event  = bus.write_inc_i & r_full;
    assign w_rbin       = gray_to_bin(r_sync[SYNC_STAGES-1]);
    assign w_wbin_next  = r_wbin + PW'(w_accept);
    assign w_level_next = w_wbin_next - w_rbin;
    assign w_thresh_eff = (bus.almost_full_thresh_i > DEPTH_W) ? DEPTH_W : bus.almost_full_thresh_i;

    // Plain flop chain: the first stage may go metastable, so nothing
    // combinational may sit between stages.
    always_ff @(posedge write_clock_i) begin
        // NOTE: non-blocking assignments so every stage samples its
        // predecessor's pre-edge value; blocking would collapse the chain.
        if (write_reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= bus.read_pointer_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge write_clock_i) begin
        if (write_reset_i) begin
            r_wbin        <= '0;
            r_wgray       <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wgray       <= w_wbin_next ^ (w_wbin_next >> 1);
            r_level       <= w_level_next;
            r_full        <= (w_level_next == DEPTH_W);
            r_almost_full <= (w_level_next >= w_thresh_eff);
            // Set beats clear when both happen in one cycle.
            r_overflow    <= w_ovf_event | (r_overflow & ~bus.write_ovf_clear_i);
        end
    end

    assign bus.write_accept_o      = w_accept;
    assign bus.write_addr_o        = r_wbin[ADDR_SIZE-1:0];
    assign bus.write_pointer_o     = r_wgray;
    assign bus.write_full_o        = r_full;
    assign bus.write_almost_full_o = r_almost_full;
    assign bus.write_level_o       = r_level;
    assign bus.write_overflow_o    = r_overflow;
endmodule

// File: tb/tb_write_ptr_flag_block.sv
// Directed bench for write_ptr_flag_block (ADDR_SIZE=3, SYNC_STAGES=2, DEPTH=8)
// with hand-computed expectations.
module tb_write_ptr_flag_block;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    write_ptr_flag_block_if #(.ADDR_SIZE(3)) bus ();

    write_ptr_flag_block #(.ADDR_SIZE(3), .SYNC_STAGES(2)) dut (
        .write_clock_i (clk),
        .write_reset_i (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    initial begin
        bus.write_inc_i          = 1'b1;
        bus.read_pointer_i       = 4'd0;
        bus.almost_full_thresh_i = 4'd6;
        bus.write_ovf_clear_i    = 1'b0;

        // Reset held with a write request pending.
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_ptr", bus.write_pointer_o, 4'b0000);
        end
        check("rst_level", bus.write_level_o, 0);
        check("rst_full", bus.write_full_o, 0);
        check("rst_af", bus.write_almost_full_o, 0);
        check("rst_ovf", bus.write_overflow_o, 0);
        check("rst_addr", bus.write_addr_o, 0);
        rst = 1'b0;
        #1;

        // Fill from empty with read pointer parked at 0.
        for (int k = 1; k <= 8; k++) begin
            check("fill_accept", bus.write_accept_o, 1);
            tick();
            check("fill_level", bus.write_level_o, k);
            check("fill_full", bus.write_full_o, (k == 8));
            check("fill_af", bus.write_almost_full_o, (k >= 6));
        end
        check("full_ptr", bus.write_pointer_o, 4'b1100);
        check("full_addr", bus.write_addr_o, 0);

        // Ninth request while full.
        check("ovf_accept", bus.write_accept_o, 0);
        tick();
        check("ovf_ptr", bus.write_pointer_o, 4'b1100);
        check("ovf_addr", bus.write_addr_o, 0);
        check("ovf_flag", bus.write_overflow_o, 1);
        check("ovf_level", bus.write_level_o, 8);

        // Clear coinciding with a fresh overflow: set wins.
        bus.write_ovf_clear_i = 1'b1;
        tick();
        check("ovf_set_wins", bus.write_overflow_o, 1);
        bus.write_inc_i = 1'b0;
        tick();
        check("ovf_cleared", bus.write_overflow_o, 0);
        bus.write_ovf_clear_i = 1'b0;

        // Read pointer moves to binary 2; visible exactly 3 edges later.
        bus.read_pointer_i = 4'b0011;
        tick();
        check("rd_lat1_full", bus.write_full_o, 1);
        tick();
        check("rd_lat2_full", bus.write_full_o, 1);
        check("rd_lat2_level", bus.write_level_o, 8);
        tick();
        check("rd_lat3_full", bus.write_full_o, 0);
        check("rd_lat3_level", bus.write_level_o, 6);
        check("rd_lat3_af", bus.write_almost_full_o, 1);

        // Wrap-around with the reader trailing by two entries.
        rst = 1'b1;
        bus.read_pointer_i = 4'd0;
        tick();
        rst = 1'b0;
        bus.almost_full_thresh_i = 4'd15;
        bus.write_inc_i = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("wrap_addr", bus.write_addr_o, k % 8);
            check("wrap_ptr", bus.write_pointer_o, gray4(k % 16));
            check("wrap_full", bus.write_full_o, 0);
            check("wrap_af", bus.write_almost_full_o, 0);
            bus.read_pointer_i = (k >= 2) ? gray4(k - 2) : 4'd0;
        end
        check("wrap_ptr_zero", bus.write_pointer_o, 4'b0000);

        // Reset in the middle of operation at level 5.
        bus.write_inc_i = 1'b0;
        rst = 1'b1;
        bus.read_pointer_i = 4'd0;
        tick();
        rst = 1'b0;
        bus.write_inc_i = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.write_inc_i = 1'b0;
        check("mid_level5", bus.write_level_o, 5);
        rst = 1'b1;
        tick();
        check("mid_rst_level", bus.write_level_o, 0);
        check("mid_rst_ptr", bus.write_pointer_o, 0);
        rst = 1'b0;

        // Threshold zero: almost-full asserts even when empty.
        bus.almost_full_thresh_i = 4'd0;
        tick();
        check("thr0_af", bus.write_almost_full_o, 1);
        check("thr0_level", bus.write_level_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
